// File: rtl/uart_tx_fifo_if.sv
// ----------------------------------------------------------------------------
// uart_tx_fifo_if
// Producer-side bundle of the UART transmitter with byte FIFO.
//   wr_valid   producer has a byte on wr_data
//   wr_data    byte to transmit
//   wr_ready   FIFO can accept a byte this cycle
//   tx         serial line, idle high
//   busy       frame in progress or FIFO non-empty
//   fifo_count bytes currently queued (0..FIFO_DEPTH)
// master = producer side, slave = transmitter side.
// ----------------------------------------------------------------------------
interface uart_tx_fifo_if #(
    parameter int FIFO_DEPTH = 16
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic          wr_valid;
    logic [7:0]    wr_data;
    logic          wr_ready;
    logic          tx;
    logic          busy;
    logic [CW-1:0] fifo_count;

    modport master (
        output wr_valid, wr_data,
        input  wr_ready, tx, busy, fifo_count
    );

    modport slave (
        input  wr_valid, wr_data,
        output wr_ready, tx, busy, fifo_count
    );
endinterface

// File: rtl/uart_tx_fifo.sv
// ----------------------------------------------------------------------------
// uart_tx_fifo
// 8N1 (or 8N2) UART transmitter fed by a byte FIFO. Bytes pushed with
// valid/ready are serialised LSB first on a registered tx line.
// Optional feature macro: UART_TX_PARITY_EN inserts an even-parity bit
// between the data bits and the stop bit(s).
// Ports:
//   clock   system clock, everything on posedge
//   resetb  asynchronous active-low reset
//   bus     uart_tx_fifo_if.slave (wr_valid, wr_data, wr_ready, tx, busy,
//           fifo_count)
// ----------------------------------------------------------------------------
module uart_tx_fifo #(
    parameter int CLK_FREQ   = 50000000,
    parameter int BAUD_RATE  = 115200,
    parameter int FIFO_DEPTH = 16,
    parameter int STOP_BITS  = 1
) (
    input  logic             clock,
    input  logic             resetb,
    uart_tx_fifo_if.slave    bus
);
    localparam int DIVISOR = CLK_FREQ / BAUD_RATE;
    localparam int BW      = $clog2(DIVISOR + 1);
    localparam int AW      = $clog2(FIFO_DEPTH);
    localparam int CW      = AW + 1;

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_STOP   = 3'd3,
        ST_PARITY = 3'd4
    } state_t;

    function automatic logic even_parity(input logic [7:0] d);
        return ^d;
    endfunction
`else
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3
    } state_t;
`endif

    state_t        state_q, state_d;
    logic [BW-1:0] baud_q, baud_d;
    logic [2:0]    bit_q, bit_d;      // data bit index, reused as stop-bit index
    logic [7:0]    shreg_q, shreg_d;
    logic          tx_q, tx_d;

    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q;

    logic          wr_ready_s;
    logic          push_s;
    logic          pop_s;
    logic          baud_wrap_s;

    assign wr_ready_s  = (count_q != CW'(FIFO_DEPTH));
    assign push_s      = bus.wr_valid & wr_ready_s;
    assign baud_wrap_s = (baud_q == BW'(DIVISOR - 1));

    // Frame sequencer: next state, baud counter, bit index, tx level and pop.
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shreg_d = shreg_q;
        tx_d    = tx_q;
        pop_s   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                baud_d = {BW{1'b0}};
                if (count_q != {CW{1'b0}}) begin
                    pop_s   = 1'b1;
                    shreg_d = mem_q[rd_ptr_q];
                    tx_d    = 1'b0;
                    state_d = ST_START;
                end else begin
                    tx_d = 1'b1;
                end
            end
            ST_START: begin
                if (baud_wrap_s) begin
                    baud_d  = {BW{1'b0}};
                    bit_d   = 3'd0;
                    tx_d    = shreg_q[0];
                    state_d = ST_DATA;
                end else begin
                    baud_d = baud_q + BW'(1);
                end
            end
            ST_DATA: begin
                if (baud_wrap_s) begin
                    baud_d = {BW{1'b0}};
                    if (bit_q == 3'd7) begin
                        bit_d = 3'd0;
`ifdef UART_TX_PARITY_EN
                        tx_d    = even_parity(shreg_q);
                        state_d = ST_PARITY;
`else
                        tx_d    = 1'b1;
                        state_d = ST_STOP;
`endif
                    end else begin
                        bit_d = bit_q + 3'd1;
                        tx_d  = shreg_q[3'(bit_q + 3'd1)];
                    end
                end else begin
                    baud_d = baud_q + BW'(1);
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                if (baud_wrap_s) begin
                    baud_d  = {BW{1'b0}};
                    bit_d   = 3'd0;
                    tx_d    = 1'b1;
                    state_d = ST_STOP;
                end else begin
                    baud_d = baud_q + BW'(1);
                end
            end
`endif
            ST_STOP: begin
                if (baud_wrap_s) begin
                    baud_d = {BW{1'b0}};
                    if (bit_q == 3'(STOP_BITS - 1)) begin
                        // Chain straight into the next start bit when data is waiting.
                        if (count_q != {CW{1'b0}}) begin
                            pop_s   = 1'b1;
                            shreg_d = mem_q[rd_ptr_q];
                            tx_d    = 1'b0;
                            state_d = ST_START;
                        end else begin
                            tx_d    = 1'b1;
                            state_d = ST_IDLE;
                        end
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    baud_d = baud_q + BW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                baud_d  = {BW{1'b0}};
                bit_d   = 3'd0;
                tx_d    = 1'b1;
            end
        endcase
    end

    // Frame sequencer registers; reset forces the line back to idle high.
    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            state_q <= ST_IDLE;
            baud_q  <= {BW{1'b0}};
            bit_q   <= 3'd0;
            shreg_q <= 8'h00;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shreg_q <= shreg_d;
            tx_q    <= tx_d;
        end
    end

    // FIFO storage; only written on an accepted push, so wr_data is don't-care otherwise.
    always_ff @(posedge clock) begin
        if (push_s) begin
            mem_q[wr_ptr_q] <= bus.wr_data;
        end else begin
            mem_q[wr_ptr_q] <= mem_q[wr_ptr_q];
        end
    end

    // FIFO pointers (wrap naturally) and occupancy counter.
    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            wr_ptr_q <= {AW{1'b0}};
            rd_ptr_q <= {AW{1'b0}};
            count_q  <= {CW{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end else begin
                wr_ptr_q <= wr_ptr_q;
            end
            if (pop_s) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end else begin
                rd_ptr_q <= rd_ptr_q;
            end
            case ({push_s, pop_s})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    assign bus.tx         = tx_q;
    assign bus.wr_ready   = wr_ready_s;
    assign bus.fifo_count = count_q;
    assign bus.busy       = (state_q != ST_IDLE) | (count_q != {CW{1'b0}});

endmodule
